seq_aru: RTL and testbench



---
 rtl/seq_aru_pkg.sv | 20 ++
 rtl/seq_aru_if.sv | 30 +++
 rtl/iter_divider.sv | 62 ++++++
 rtl/seq_aru.sv | 193 +++++++++++++++++++
 tb/tb_seq_aru.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/seq_aru_pkg.sv
// Shared definitions for the sequential arithmetic unit: op codes, FSM states
// and the default datapath width.
package seq_aru_pkg;

    localparam int SEQ_ARU_W = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } aru_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MUL_RUN = 2'b01,
        DIV_RUN = 2'b10
    } aru_state_t;

endpackage

// File: rtl/seq_aru_if.sv
// Controller-to-ARU bus: request signals, status handshake and registered results.
interface seq_aru_if #(parameter int W = seq_aru_pkg::SEQ_ARU_W);

    // start is sampled on a rising edge only while busy=0; an accepted start
    // produces exactly one done pulse, and out/rem/flags are valid from that cycle.
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic [W-1:0] rem;
    logic         Z;
    logic         N;
    logic         C;
    logic         V;
    logic         DZ;

    modport master (
        output start, op, in0, in1,
        input  busy, done, out, rem, Z, N, C, V, DZ
    );

    modport slave (
        input  start, op, in0, in1,
        output busy, done, out, rem, Z, N, C, V, DZ
    );

endinterface

// File: rtl/iter_divider.sv
// W-step unsigned restoring divider. o_last marks the final step; o_quot/o_rem
// then carry the finished quotient and remainder for the caller to register.
module iter_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_last,
    output logic [W-1:0] o_quot,
    output logic [W-1:0] o_rem
);

    localparam int CW = $clog2(W) + 1;

    logic          r_run;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_quot;
    logic [W-1:0]  r_div;

    logic [W:0]    w_shift;
    logic [W:0]    w_diff;
    logic          w_ge;

    // Partial remainder needs one extra bit before the trial subtract; the
    // borrow bit of the difference says whether the divisor fits.
    always_comb begin
        w_shift = {r_rem, r_quot[W-1]};
        w_diff  = w_shift - {1'b0, r_div};
        w_ge    = ~w_diff[W];
        o_rem   = w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
        o_quot  = {r_quot[W-2:0], w_ge};
        o_last  = r_run && (r_cnt == CW'(W - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run  <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quot <= '0;
            r_div  <= '0;
        end else if (i_load) begin
            r_run  <= 1'b1;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quot <= i_dividend;
            r_div  <= i_divisor;
        end else if (r_run) begin
            r_rem  <= o_rem;
            r_quot <= o_quot;
            r_cnt  <= r_cnt + CW'(1);
            if (o_last) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_aru.sv
// Multi-cycle ARU: single-cycle ADD/SUB, shift-add signed MUL of the low
// halves, and restoring unsigned DIV, with registered results and flags.
module seq_aru
    import seq_aru_pkg::*;
#(
    parameter int W = SEQ_ARU_W
) (
    input  logic       clk,
    input  logic       rst,
    seq_aru_if.slave   io_bus,
    output aru_state_t o_state
);

    localparam int H  = W / 2;
    localparam int CW = $clog2(W) + 1;

    aru_state_t    r_state;
    aru_state_t    w_state_nxt;

    logic [W-1:0]  r_mcand;
    logic [H-1:0]  r_mplier;
    logic [W-1:0]  r_prod;
    logic          r_neg;
    logic [CW-1:0] r_cnt;

    logic [W-1:0]  r_out;
    logic [W-1:0]  r_rem;
    logic          r_z, r_n, r_c, r_v, r_dz, r_done;

    logic          w_start_ok;
    logic [W:0]    w_sum;
    logic [W:0]    w_dif;
    logic [H-1:0]  w_a, w_b, w_mag_a, w_mag_b;
    logic [W-1:0]  w_prod_add, w_prod_fix;
    logic          w_mul_load, w_mul_last;
    logic          w_div_load, w_div_last;
    logic [W-1:0]  w_div_quot, w_div_rem;

    logic          w_ld_res;
    logic [W-1:0]  w_res_out, w_res_rem;
    logic          w_res_c, w_res_v, w_res_dz;

    always_comb begin
        w_start_ok = io_bus.start && (r_state == IDLE);
        w_sum      = {1'b0, io_bus.in0} + {1'b0, io_bus.in1};
        w_dif      = {1'b0, io_bus.in0} - {1'b0, io_bus.in1};
        w_a        = io_bus.in0[H-1:0];
        w_b        = io_bus.in1[H-1:0];
        // Unsigned H-bit magnitude covers -2^(H-1) as well.
        w_mag_a    = w_a[H-1] ? (H'(0) - w_a) : w_a;
        w_mag_b    = w_b[H-1] ? (H'(0) - w_b) : w_b;
        w_prod_add = r_prod + (r_mplier[0] ? r_mcand : '0);
        w_prod_fix = r_neg ? (W'(0) - w_prod_add) : w_prod_add;
        w_mul_load = w_start_ok && (aru_op_t'(io_bus.op) == OP_MUL);
        w_mul_last = (r_state == MUL_RUN) && (r_cnt == CW'(H - 1));
        w_div_load = w_start_ok && (aru_op_t'(io_bus.op) == OP_DIV) && (io_bus.in1 != '0);
    end

    iter_divider #(.W(W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_div_load),
        .i_dividend (io_bus.in0),
        .i_divisor  (io_bus.in1),
        .o_last     (w_div_last),
        .o_quot     (w_div_quot),
        .o_rem      (w_div_rem)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ld_res    = 1'b0;
        w_res_out   = '0;
        w_res_rem   = '0;
        w_res_c     = 1'b0;
        w_res_v     = 1'b0;
        w_res_dz    = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_bus.start) begin
                    case (aru_op_t'(io_bus.op))
                        OP_ADD: begin
                            w_ld_res  = 1'b1;
                            w_res_out = w_sum[W-1:0];
                            w_res_c   = w_sum[W];
                            w_res_v   = (io_bus.in0[W-1] == io_bus.in1[W-1]) &&
                                        (w_sum[W-1] != io_bus.in0[W-1]);
                        end
                        OP_SUB: begin
                            w_ld_res  = 1'b1;
                            w_res_out = w_dif[W-1:0];
                            w_res_c   = w_dif[W];
                            w_res_v   = (io_bus.in0[W-1] != io_bus.in1[W-1]) &&
                                        (w_dif[W-1] != io_bus.in0[W-1]);
                        end
                        OP_MUL: w_state_nxt = MUL_RUN;
                        OP_DIV: begin
                            if (io_bus.in1 == '0) begin
                                w_ld_res  = 1'b1;
                                w_res_out = '1;
                                w_res_rem = io_bus.in0;
                                w_res_dz  = 1'b1;
                            end else begin
                                w_state_nxt = DIV_RUN;
                            end
                        end
                    endcase
                end
            end
            MUL_RUN: begin
                if (w_mul_last) begin
                    w_ld_res    = 1'b1;
                    w_res_out   = w_prod_fix;
                    w_state_nxt = IDLE;
                end
            end
            DIV_RUN: begin
                if (w_div_last) begin
                    w_ld_res    = 1'b1;
                    w_res_out   = w_div_quot;
                    w_res_rem   = w_div_rem;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_mul_load) begin
            r_mcand  <= {{(W-H){1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_prod   <= '0;
            r_neg    <= w_a[H-1] ^ w_b[H-1];
            r_cnt    <= '0;
        end else if (r_state == MUL_RUN) begin
            r_prod   <= w_prod_add;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done <= 1'b0;
            r_out  <= '0;
            r_rem  <= '0;
            r_z    <= 1'b0;
            r_n    <= 1'b0;
            r_c    <= 1'b0;
            r_v    <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= w_ld_res;
            if (w_ld_res) begin
                r_out <= w_res_out;
                r_rem <= w_res_rem;
                r_z   <= (w_res_out == '0);
                r_n   <= w_res_out[W-1];
                r_c   <= w_res_c;
                r_v   <= w_res_v;
                r_dz  <= w_res_dz;
            end
        end
    end

    assign io_bus.busy = (r_state != IDLE);
    assign io_bus.done = r_done;
    assign io_bus.out  = r_out;
    assign io_bus.rem  = r_rem;
    assign io_bus.Z    = r_z;
    assign io_bus.N    = r_n;
    assign io_bus.C    = r_c;
    assign io_bus.V    = r_v;
    assign io_bus.DZ   = r_dz;
    assign o_state     = r_state;

endmodule

// File: tb/tb_seq_aru.sv
// Directed bench for seq_aru (W=16): each step drives one operation and checks
// latency, handshake and results against hand-computed values.
module tb_seq_aru;
    import seq_aru_pkg::*;

    logic       clk;
    logic       rst;
    aru_state_t dbg_state;
    int         total;
    int         bad;
    int         ndone;
    int         nbusy;

    seq_aru_if #(.W(16)) io_bus ();

    seq_aru #(.W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_bus  (io_bus),
        .o_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [15:0] e_out, input logic [15:0] e_rem,
                           input logic e_z, input logic e_n, input logic e_c, input logic e_v,
                           input logic e_dz);
        chk({tag, ".out"}, 32'(io_bus.out), 32'(e_out));
        chk({tag, ".rem"}, 32'(io_bus.rem), 32'(e_rem));
        chk({tag, ".Z"},   32'(io_bus.Z),   32'(e_z));
        chk({tag, ".N"},   32'(io_bus.N),   32'(e_n));
        chk({tag, ".C"},   32'(io_bus.C),   32'(e_c));
        chk({tag, ".V"},   32'(io_bus.V),   32'(e_v));
        chk({tag, ".DZ"},  32'(io_bus.DZ),  32'(e_dz));
    endtask

    // Leaves the caller at the negedge of cycle t+1 after acceptance edge t.
    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        io_bus.start = 1'b1;
        io_bus.op    = op;
        io_bus.in0   = a;
        io_bus.in1   = b;
        @(negedge clk);
        io_bus.start = 1'b0;
        io_bus.in0   = 16'hDEAD;
        io_bus.in1   = 16'hBEEF;
    endtask

    task automatic expect_busy(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk({tag, ".busy"}, 32'(io_bus.busy), 32'd1);
            chk({tag, ".nodone"}, 32'(io_bus.done), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        io_bus.start = 1'b0;
        io_bus.op    = 2'b00;
        io_bus.in0   = '0;
        io_bus.in1   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.busy", 32'(io_bus.busy), 32'd0);
        chk("rst.done", 32'(io_bus.done), 32'd0);
        chk("rst.state", 32'(dbg_state), 32'(IDLE));
        chk_res("rst", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // ADD with signed overflow
        issue(OP_ADD, 16'h7FFF, 16'h0001);
        chk("add.done", 32'(io_bus.done), 32'd1);
        chk_res("add", 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("add.pulse", 32'(io_bus.done), 32'd0);
        chk("add.hold", 32'(io_bus.out), 32'h8000);

        // SUB with borrow, then SUB to zero
        issue(OP_SUB, 16'h0003, 16'h0005);
        chk("sub1.done", 32'(io_bus.done), 32'd1);
        chk_res("sub1", 16'hFFFE, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(OP_SUB, 16'h0005, 16'h0005);
        chk("sub2.done", 32'(io_bus.done), 32'd1);
        chk_res("sub2", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back ADDs: done every cycle
        @(negedge clk);
        io_bus.start = 1'b1;
        io_bus.op    = OP_ADD;
        io_bus.in0   = 16'd1;
        io_bus.in1   = 16'd2;
        @(negedge clk);
        chk("b2b1.done", 32'(io_bus.done), 32'd1);
        chk("b2b1.out", 32'(io_bus.out), 32'd3);
        io_bus.in0 = 16'd5;
        io_bus.in1 = 16'd6;
        @(negedge clk);
        io_bus.start = 1'b0;
        chk("b2b2.done", 32'(io_bus.done), 32'd1);
        chk("b2b2.out", 32'(io_bus.out), 32'd11);
        @(negedge clk);
        chk("b2b.end", 32'(io_bus.done), 32'd0);

        // MUL -3*7 with an ignored start mid-run
        issue(OP_MUL, 16'h12FD, 16'hAB07);
        ndone = 0;
        for (int i = 1; i <= 8; i++) begin
            chk("mul1.busy", 32'(io_bus.busy), 32'd1);
            if (io_bus.done) ndone++;
            if (i == 3) begin
                io_bus.start = 1'b1;
                io_bus.op    = OP_ADD;
                io_bus.in0   = 16'h0001;
                io_bus.in1   = 16'h0001;
            end else begin
                io_bus.start = 1'b0;
            end
            @(negedge clk);
        end
        chk("mul1.nodone_run", 32'(ndone), 32'd0);
        chk("mul1.done", 32'(io_bus.done), 32'd1);
        chk("mul1.idle", 32'(io_bus.busy), 32'd0);
        chk_res("mul1", 16'hFFEB, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Start in the done cycle: (-128)*(-128)
        io_bus.start = 1'b1;
        io_bus.op    = OP_MUL;
        io_bus.in0   = 16'h0080;
        io_bus.in1   = 16'h0080;
        @(negedge clk);
        io_bus.start = 1'b0;
        chk("mul1.pulse", 32'(io_bus.done), 32'd0);
        expect_busy(8, "mul2");
        chk("mul2.done", 32'(io_bus.done), 32'd1);
        chk_res("mul2", 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // DIV 100/7
        issue(OP_DIV, 16'd100, 16'd7);
        expect_busy(16, "div1");
        chk("div1.done", 32'(io_bus.done), 32'd1);
        chk_res("div1", 16'd14, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // DIV by zero
        issue(OP_DIV, 16'h1234, 16'h0000);
        chk("dz.done", 32'(io_bus.done), 32'd1);
        chk("dz.busy", 32'(io_bus.busy), 32'd0);
        chk_res("dz", 16'hFFFF, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // ADD with carry out to zero; clears DZ and rem
        issue(OP_ADD, 16'hFFFF, 16'h0001);
        chk("addc.done", 32'(io_bus.done), 32'd1);
        chk_res("addc", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a DIV
        issue(OP_DIV, 16'd1000, 16'd3);
        repeat (4) @(negedge clk);
        chk("divrst.busy_before", 32'(io_bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("divrst.busy", 32'(io_bus.busy), 32'd0);
        chk("divrst.done", 32'(io_bus.done), 32'd0);
        chk("divrst.state", 32'(dbg_state), 32'(IDLE));
        chk_res("divrst", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (io_bus.done) ndone++;
            if (io_bus.busy) nbusy++;
        end
        chk("divrst.no_done", 32'(ndone), 32'd0);
        chk("divrst.no_busy", 32'(nbusy), 32'd0);

        // First start after reset release is honoured
        issue(OP_SUB, 16'h8000, 16'h0001);
        chk("post.done", 32'(io_bus.done), 32'd1);
        chk_res("post", 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
